// File: rtl/nvdla_rr_muxn.sv
// nvdla_rr_muxn: N-channel registered multiplexer with valid/ready handshake,
// round-robin arbitration and packet locking. While a multi-beat packet is in
// flight, only its source channel is considered, so packets never interleave.
module nvdla_rr_muxn #(
  parameter  int WIDTH = 32,
  parameter  int NCH   = 4,
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rst,
  input  logic [NCH-1:0]       in_vld,
  output logic [NCH-1:0]       in_rdy,
  input  logic [NCH*WIDTH-1:0] in_pd,
  input  logic [NCH-1:0]       in_last,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [WIDTH-1:0]     out_pd,
  output logic                 out_last,
  output logic [CW-1:0]        out_src
);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_e;

  localparam logic [CW:0]   NCH_W  = (CW+1)'(NCH);
  localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

  lock_state_e         state_q;
  logic [CW-1:0]       ptr_q;
  logic [CW-1:0]       lock_ch_q;
  logic                out_vld_q;
  logic [WIDTH-1:0]    out_pd_q;
  logic                out_last_q;
  logic [CW-1:0]       out_src_q;

  logic                ld;
  logic                acc;
  logic [NCH-1:0]      grant;
  logic                sel_vld;
  logic [CW-1:0]       sel_idx;
  logic [CW:0]         scan;
  logic [CW-1:0]       cand;
  logic [WIDTH-1:0]    sel_pd;
  logic                sel_last;
  logic [CW-1:0]       ptr_d;

  // Arbitration: locked channel only, else first requester at or after ptr.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    grant   = '0;
    sel_vld = 1'b0;
    sel_idx = '0;
    scan    = '0;
    cand    = '0;
    if (state_q == ST_LOCKED) begin
      sel_idx = lock_ch_q;
      sel_vld = in_vld[lock_ch_q];
    end else begin
      for (int k = 0; k < NCH; k++) begin
        scan = {1'b0, ptr_q} + (CW+1)'(k);
        if (scan >= NCH_W) scan = scan - NCH_W;
        cand = scan[CW-1:0];
        if (!sel_vld && in_vld[cand]) begin
          sel_vld = 1'b1;
          sel_idx = cand;
        end
      end
    end
    grant[sel_idx] = sel_vld;
  end

  assign ld       = !out_vld_q || out_rdy;
  assign acc      = sel_vld && ld;
  assign in_rdy   = grant & {NCH{ld}};
  assign sel_pd   = in_pd[int'(sel_idx) * WIDTH +: WIDTH];
  assign sel_last = in_last[sel_idx];
  assign ptr_d    = (sel_idx == LAST_CH) ? '0 : sel_idx + CW'(1);

  // Output register and lock FSM, both advanced by the accept handshake.
  always_ff @(posedge nvdla_core_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (nvdla_core_rst) begin
      state_q    <= ST_UNLOCKED;
      ptr_q      <= '0;
      lock_ch_q  <= '0;
      out_vld_q  <= 1'b0;
      out_pd_q   <= '0;
      out_last_q <= 1'b0;
      out_src_q  <= '0;
    end else begin
      if (ld) begin
        out_vld_q <= acc;
        if (acc) begin
          out_pd_q   <= sel_pd;
          out_last_q <= sel_last;
          out_src_q  <= sel_idx;
        end
      end
      if (acc) begin
        if (state_q == ST_UNLOCKED) begin
          if (sel_last) begin
            ptr_q <= ptr_d;
          end else begin
            state_q   <= ST_LOCKED;
            lock_ch_q <= sel_idx;
          end
        end else if (sel_last) begin
          state_q <= ST_UNLOCKED;
          ptr_q   <= ptr_d;
        end
      end
    end
  end

  assign out_vld  = out_vld_q;
  assign out_pd   = out_pd_q;
  assign out_last = out_last_q;
  assign out_src  = out_src_q;

endmodule

// File: tb/tb_nvdla_rr_muxn.sv
// Self-checking bench for nvdla_rr_muxn: a 4-channel and a 3-channel instance
// share randomized stimulus; a behavioural arbiter model pushes expected beats
// into per-instance queues that a separate monitor drains and compares.
module tb_nvdla_rr_muxn;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   vld;
  logic [3:0]   last;
  logic [127:0] pd;
  logic         ordy4, ordy3;

  logic [3:0]   rdy4;
  logic         ov4, ol4;
  logic [31:0]  opd4;
  logic [1:0]   osrc4;

  logic [2:0]   rdy3;
  logic         ov3, ol3;
  logic [31:0]  opd3;
  logic [1:0]   osrc3;

  always #5 clk = ~clk;

  nvdla_rr_muxn #(.WIDTH(32), .NCH(4)) u_dut4 (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst),
    .in_vld(vld), .in_rdy(rdy4), .in_pd(pd), .in_last(last),
    .out_vld(ov4), .out_rdy(ordy4), .out_pd(opd4), .out_last(ol4), .out_src(osrc4)
  );

  nvdla_rr_muxn #(.WIDTH(32), .NCH(3)) u_dut3 (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst),
    .in_vld(vld[2:0]), .in_rdy(rdy3), .in_pd(pd[95:0]), .in_last(last[2:0]),
    .out_vld(ov3), .out_rdy(ordy3), .out_pd(opd3), .out_last(ol3), .out_src(osrc3)
  );

  typedef struct {
    logic [31:0] pd;
    logic        last;
    int          src;
  } beat_t;

  beat_t q4[$];
  beat_t q3[$];

  // Reference arbiter state per instance (0: NCH=4, 1: NCH=3).
  int mptr[2];
  bit mlock[2];
  int mlch[2];

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Which channel the rules pick this cycle, or -1 for none.
  function automatic int model_grant(input int d, input int nch, input logic [3:0] v);
    if (mlock[d]) return v[mlch[d]] ? mlch[d] : -1;
    for (int k = 0; k < nch; k++) begin
      int c;
      c = (mptr[d] + k) % nch;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Predict in_rdy and any accepted beat for instance d, then advance the model.
  task automatic model_step(input int d);
    int         nch;
    logic       ordy;
    int         qs;
    bit         ld;
    int         g;
    logic [3:0] exp_rdy;
    logic [3:0] act_rdy;
    beat_t      b;
    nch     = (d == 0) ? 4 : 3;
    ordy    = (d == 0) ? ordy4 : ordy3;
    qs      = (d == 0) ? q4.size() : q3.size();
    act_rdy = (d == 0) ? rdy4 : {1'b0, rdy3};
    ld      = (qs == 0) || ordy;
    g       = model_grant(d, nch, (d == 0) ? vld : {1'b0, vld[2:0]});
    exp_rdy = '0;
    if (ld && g >= 0) begin
      exp_rdy = 4'(1) << g;
      b.pd    = pd[g*32 +: 32];
      b.last  = last[g];
      b.src   = g;
      if (d == 0) q4.push_back(b); else q3.push_back(b);
      if (b.last) begin
        mlock[d] = 1'b0;
        mptr[d]  = (g + 1) % nch;
      end else begin
        mlock[d] = 1'b1;
        mlch[d]  = g;
      end
    end
    check((d == 0) ? "in_rdy_nch4" : "in_rdy_nch3", 64'(act_rdy), 64'(exp_rdy));
  endtask

  // Compare the visible output register against the oldest outstanding beat.
  task automatic mon(input int d);
    logic        ov, ordy, ol;
    logic [31:0] opd;
    int          os;
    int          qs;
    beat_t       h;
    ov   = (d == 0) ? ov4 : ov3;
    ordy = (d == 0) ? ordy4 : ordy3;
    ol   = (d == 0) ? ol4 : ol3;
    opd  = (d == 0) ? opd4 : opd3;
    os   = (d == 0) ? int'(osrc4) : int'(osrc3);
    qs   = (d == 0) ? q4.size() : q3.size();
    check((d == 0) ? "out_vld_nch4" : "out_vld_nch3", 64'(ov), 64'(qs > 0));
    if (ov && qs > 0) begin
      h = (d == 0) ? q4[0] : q3[0];
      check((d == 0) ? "out_pd_nch4" : "out_pd_nch3", 64'(opd), 64'(h.pd));
      check((d == 0) ? "out_last_nch4" : "out_last_nch3", 64'(ol), 64'(h.last));
      check((d == 0) ? "out_src_nch4" : "out_src_nch3", 64'(os), 64'(h.src));
      if (ordy) begin
        if (d == 0) void'(q4.pop_front()); else void'(q3.pop_front());
      end
    end
  endtask

  // Monitor: runs between input drive (+1) and model step (+5) each cycle.
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (mon_en) begin
        mon(0);
        mon(1);
      end
    end
  end

  // One stimulus cycle: percentages for valid, last and downstream ready.
  task automatic cycle(input int p_vld, input int p_last, input int p_ordy,
                       input logic [3:0] mask, input bit rr_pd);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      vld[i]         = mask[i] && ($urandom_range(99) < p_vld);
      last[i]        = $urandom_range(99) < p_last;
      pd[i*32 +: 32] = rr_pd ? 32'hA0 + 32'(i) : $urandom;
    end
    ordy4 = $urandom_range(99) < p_ordy;
    ordy3 = $urandom_range(99) < p_ordy;
    #4;
    model_step(0);
    model_step(1);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst    = 1'b1;
    mon_en = 1'b0;
    vld    = '0;
    last   = '0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    q4.delete();
    q3.delete();
    for (int d = 0; d < 2; d++) begin
      mptr[d]  = 0;
      mlock[d] = 1'b0;
      mlch[d]  = 0;
    end
    mon_en = 1'b1;
  endtask

  initial begin
    rst   = 1'b1;
    vld   = '0;
    last  = '0;
    pd    = '0;
    ordy4 = 1'b0;
    ordy3 = 1'b0;
    do_reset(3);

    // Idle after reset: nothing requested, output register stays cleared.
    repeat (5) begin
      cycle(0, 100, 50, 4'hF, 1'b0);
      check("idle_pd_nch4", 64'(opd4), 64'h0);
      check("idle_src_nch4", 64'(osrc4), 64'h0);
      check("idle_pd_nch3", 64'(opd3), 64'h0);
      check("idle_src_nch3", 64'(osrc3), 64'h0);
    end

    // Round-robin fairness: all channels busy with single-beat packets.
    repeat (12) cycle(100, 100, 100, 4'hF, 1'b1);

    // Mixed multi-beat packets with moderate backpressure.
    repeat (300) cycle(50, 33, 70, 4'hF, 1'b0);

    // Heavy backpressure.
    repeat (200) cycle(60, 40, 20, 4'hF, 1'b0);

    // Long packets to exercise locking against competing requesters.
    repeat (200) cycle(80, 10, 80, 4'hF, 1'b0);

    // Wrap: only ch2 and ch0 request single beats.
    repeat (40) cycle(100, 100, 100, 4'b0101, 1'b0);

    // Reset mid-packet, then ch0 and ch3 compete from a cleared pointer.
    for (int r = 0; r < 6; r++) begin
      repeat (25) cycle(90, 10, 70, 4'hF, 1'b0);
      do_reset(1);
      repeat (4) cycle(100, 100, 100, 4'b1001, 1'b0);
    end

    repeat (3) cycle(0, 100, 100, 4'hF, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
